muldiv_ctrl: RTL

- Multi-cycle sequencer for the CPU's MUL and DIV operations (ALU ops 3'b010 MULA, 3'b011 DIVA).
- Runs an iterative shift-add multiplier and a restoring shift-subtract divider, one bit per cycle, behind a start/busy/done handshake.
- Execute stage stalls on busy and captures result on done.
- Single-cycle ALU ops (ADD/SUB/AND/OR/XOR/NOT) never enter this block.

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/muldiv_dp.sv | 63 ++++++
 rtl/muldiv_ctrl.sv | 124 ++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU op codes and the multi-cycle mul/div sequencer states.
package cpu_pkg;

  localparam logic [2:0] ADDA = 3'b000;
  localparam logic [2:0] SUBA = 3'b001;
  localparam logic [2:0] MULA = 3'b010;
  localparam logic [2:0] DIVA = 3'b011;
  localparam logic [2:0] ANDA = 3'b100;
  localparam logic [2:0] ORA  = 3'b101;
  localparam logic [2:0] XORA = 3'b110;
  localparam logic [2:0] NOTA = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    MUL_RUN,
    DIV_RUN,
    DONE
  } muldiv_state_t;

  // Only the two multi-cycle ops are ever routed to the mul/div sequencer.
  function automatic logic is_muldiv_op(input logic [2:0] op);
    return (op == MULA) || (op == DIVA);
  endfunction

endpackage

// File: rtl/muldiv_dp.sv
// Shared shift register datapath: shift-add multiply and restoring shift-subtract divide,
// one bit per step. acc holds the partial product / remainder, sreg the multiplier / quotient.
module muldiv_dp
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             is_div,
  input  logic             step_mul,
  input  logic             step_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res_next
);

  logic [WIDTH:0]   acc_reg;
  logic [WIDTH:0]   acc_next;
  logic [WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0] sreg_reg;
  logic [WIDTH-1:0] sreg_next;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_diff;
  logic             rem_ge;

  always_comb begin
    mul_sum   = sreg_reg[0] ? (acc_reg + {1'b0, mcand_reg}) : acc_reg;
    rem_shift = {acc_reg[WIDTH-1:0], sreg_reg[WIDTH-1]};
    rem_ge    = (rem_shift >= {1'b0, mcand_reg});
    rem_diff  = rem_shift - {1'b0, mcand_reg};
    acc_next  = acc_reg;
    sreg_next = sreg_reg;
    if (step_mul) begin
      acc_next  = mul_sum >> 1;
      sreg_next = {mul_sum[0], sreg_reg[WIDTH-1:1]};
    end else if (step_div) begin
      // The remainder stays below the divisor, so its top bit is always zero.
      acc_next  = rem_ge ? rem_diff : rem_shift;
      sreg_next = {sreg_reg[WIDTH-2:0], rem_ge};
    end
  end

  assign res_next = sreg_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg   <= '0;
      mcand_reg <= '0;
      sreg_reg  <= '0;
    end else if (load) begin
      acc_reg   <= '0;
      mcand_reg <= is_div ? b : a;
      sreg_reg  <= is_div ? a : b;
    end else begin
      acc_reg   <= acc_next;
      sreg_reg  <= sreg_next;
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle MUL/DIV sequencer: FSM, step counter and start/busy/done handshake
// around the iterative datapath. All outputs are registered.
module muldiv_ctrl
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [1:0]       flags,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  muldiv_state_t    state_reg;
  logic [CW-1:0]    count_reg;
  logic             busy_reg;
  logic             done_reg;
  logic [WIDTH-1:0] result_reg;
  logic [1:0]       flags_reg;
  logic             dbz_reg;

  logic             can_accept;
  logic             accept;
  logic             accept_div;
  logic             div_zero;
  logic             step_mul;
  logic             step_div;
  logic [WIDTH-1:0] res_next;
  logic [1:0]       res_flags;

  always_comb begin
    can_accept = (state_reg == IDLE) || (state_reg == DONE);
    accept     = can_accept && start && !flush && is_muldiv_op(op);
    accept_div = accept && (op == DIVA);
    div_zero   = accept_div && (b == '0);
    step_mul   = (state_reg == MUL_RUN) && !flush;
    step_div   = (state_reg == DIV_RUN) && !flush;
    res_flags  = {res_next[WIDTH-1], res_next == '0};
  end

  muldiv_dp #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .is_div   (accept_div),
    .step_mul (step_mul),
    .step_div (step_div),
    .a        (a),
    .b        (b),
    .res_next (res_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      result_reg <= '0;
      flags_reg  <= 2'b01;
      dbz_reg    <= 1'b0;
    end else begin
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
      case (state_reg)
        IDLE, DONE: begin
          if (accept) begin
            count_reg <= '0;
            if (div_zero) begin
              // Divide by zero completes immediately with an all-ones quotient.
              state_reg  <= DONE;
              done_reg   <= 1'b1;
              result_reg <= '1;
              flags_reg  <= 2'b10;
              dbz_reg    <= 1'b1;
            end else begin
              state_reg <= accept_div ? DIV_RUN : MUL_RUN;
              busy_reg  <= 1'b1;
              dbz_reg   <= 1'b0;
            end
          end else begin
            state_reg <= IDLE;
          end
        end
        MUL_RUN, DIV_RUN: begin
          if (flush) begin
            state_reg <= IDLE;
          end else begin
            count_reg <= count_reg + 1'b1;
            if (count_reg == LAST_STEP) begin
              state_reg  <= DONE;
              done_reg   <= 1'b1;
              result_reg <= res_next;
              flags_reg  <= res_flags;
            end else begin
              busy_reg <= 1'b1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy        = busy_reg;
  assign done        = done_reg;
  assign result      = result_reg;
  assign flags       = flags_reg;
  assign div_by_zero = dbz_reg;

endmodule
